// File: rtl/ace_line_ctrl.sv
// Direct-mapped ACE-style line controller: NP/SC/E/M/SM lines,
// AXI master for fills, write-through and victim write-back, plus snoop port.
module ace_line_ctrl #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_done,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic                  shared_in,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [ADDR_W-1:0]     snp_addr,
  input  logic                  snp_inv,
  output logic                  snp_resp_valid,
  output logic                  snp_hit,
  output logic                  snp_dirty,
  output logic [DATA_W-1:0]     snp_data,
  output logic [3*LINES-1:0]    line_state
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = ADDR_W - OFF - IDX;
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'((1 << OFF) - 1);

  typedef enum logic [2:0] {
    L_NP = 3'd0,
    L_SC = 3'd1,
    L_M  = 3'd2,
    L_SM = 3'd3,
    L_E  = 3'd4
  } lst_t;

  typedef enum logic [2:0] {
    IDLE, WB_ADDR, WB_RESP, RD_ADDR,
    RD_DATA, WT_ADDR, WT_RESP, DONE
  } fsm_t;

  fsm_t cs, ns;

  lst_t             st    [LINES];
  logic [TW-1:0]    tag_q [LINES];
  logic [DATA_W-1:0] dat_q [LINES];

  logic [ADDR_W-1:0] req_addr, aw_q;
  logic [DATA_W-1:0] req_wdata, wd_q;
  logic              req_we;
  logic              aw_ok, w_ok;

  logic [IDX-1:0] c_idx, s_idx, r_idx;
  logic [TW-1:0]  c_tag, s_tag, r_tag;
  lst_t           c_st, s_st;
  logic           c_hit, c_dirty, c_own, s_hit;
  logic           cpu_hs, snp_hs;
  logic           aw_hs, w_hs, ar_hs, r_hs, b_hs;
  logic           addr_st, both;
  logic           unused_snp;

  function automatic logic [ADDR_W-1:0] laddr(
    input logic [TW-1:0]  t,
    input logic [IDX-1:0] i
  );
    return ADDR_W'({t, i}) << OFF;
  endfunction

  assign c_idx = cpu_addr[OFF +: IDX];
  assign c_tag = cpu_addr[OFF+IDX +: TW];
  assign s_idx = snp_addr[OFF +: IDX];
  assign s_tag = snp_addr[OFF+IDX +: TW];
  assign r_idx = req_addr[OFF +: IDX];
  assign r_tag = req_addr[OFF+IDX +: TW];
  assign unused_snp = |(snp_addr & ~AMASK);

  assign c_st    = st[c_idx];
  assign s_st    = st[s_idx];
  assign c_hit   = (c_st != L_NP) && (tag_q[c_idx] == c_tag);
  assign s_hit   = (s_st != L_NP) && (tag_q[s_idx] == s_tag);
  assign c_dirty = (c_st == L_M) || (c_st == L_SM);
  assign c_own   = (c_st == L_M) || (c_st == L_E);

  assign snp_ready     = (cs == IDLE);
  assign cpu_req_ready = (cs == IDLE) && !snp_valid;
  assign snp_hs        = snp_valid && snp_ready;
  assign cpu_hs        = cpu_req_valid && cpu_req_ready;

  assign addr_st  = (cs == WB_ADDR) || (cs == WT_ADDR);
  assign arvalid  = (cs == RD_ADDR);
  assign awvalid  = addr_st && !aw_ok;
  assign wvalid   = addr_st && !w_ok;
  assign rready   = (cs == RD_DATA);
  assign bready   = (cs == WB_RESP) || (cs == WT_RESP);
  assign cpu_done = (cs == DONE);
  assign araddr   = req_addr & AMASK;
  assign awaddr   = aw_q;
  assign wdata    = wd_q;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign both  = (aw_ok || aw_hs) && (w_ok || w_hs);

  always_comb begin
    line_state = '0;
    for (int i = 0; i < LINES; i++)
      line_state[3*i +: 3] = st[i];
  end

  always_comb begin
    ns = cs;
    unique case (cs)
      IDLE: if (cpu_hs) begin
        unique case (1'b1)
          c_hit && (!cpu_we || c_own):   ns = DONE;
          c_hit && cpu_we && !c_own:     ns = WT_ADDR;
          !c_hit && c_dirty:             ns = WB_ADDR;
          !c_hit && !c_dirty && cpu_we:  ns = WT_ADDR;
          default:                       ns = RD_ADDR;
        endcase
      end
      WB_ADDR: if (both) ns = WB_RESP;
      WB_RESP: if (b_hs) ns = req_we ? WT_ADDR : RD_ADDR;
      RD_ADDR: if (ar_hs) ns = RD_DATA;
      RD_DATA: if (r_hs) ns = DONE;
      WT_ADDR: if (both) ns = WT_RESP;
      WT_RESP: if (b_hs) ns = DONE;
      DONE:    ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs             <= IDLE;
      req_addr       <= '0;
      req_we         <= 1'b0;
      req_wdata      <= '0;
      aw_q           <= '0;
      wd_q           <= '0;
      aw_ok          <= 1'b0;
      w_ok           <= 1'b0;
      cpu_rdata      <= '0;
      snp_resp_valid <= 1'b0;
      snp_hit        <= 1'b0;
      snp_dirty      <= 1'b0;
      snp_data       <= '0;
      for (int i = 0; i < LINES; i++)
        st[i] <= L_NP;
    end else begin
      cs             <= ns;
      snp_resp_valid <= 1'b0;
      if (addr_st && !both) begin
        aw_ok <= aw_ok || aw_hs;
        w_ok  <= w_ok || w_hs;
      end else begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end
      unique case (cs)
        IDLE: begin
          if (snp_hs) begin
            snp_resp_valid <= 1'b1;
            snp_hit        <= s_hit;
            snp_dirty      <= s_hit && (s_st == L_M || s_st == L_SM);
            snp_data       <= s_hit ? dat_q[s_idx] : '0;
            if (s_hit) begin
              if (snp_inv)          st[s_idx] <= L_NP;
              else if (s_st == L_M) st[s_idx] <= L_SM;
              else if (s_st == L_E) st[s_idx] <= L_SC;
            end
          end else if (cpu_hs) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            if (c_hit && !cpu_we)
              cpu_rdata <= dat_q[c_idx];
            if (c_hit && cpu_we && c_own)
              st[c_idx] <= L_M;
            // victim write-back takes precedence over the new request
            if (!c_hit && c_dirty) begin
              aw_q <= laddr(tag_q[c_idx], c_idx);
              wd_q <= dat_q[c_idx];
            end else begin
              aw_q <= cpu_addr & AMASK;
              wd_q <= cpu_wdata;
            end
          end
        end
        WB_RESP: if (b_hs) begin
          st[r_idx] <= L_NP;
          aw_q      <= req_addr & AMASK;
          wd_q      <= req_wdata;
        end
        RD_DATA: if (r_hs) begin
          st[r_idx] <= shared_in ? L_SC : L_E;
          cpu_rdata <= rdata;
        end
        WT_RESP: if (b_hs)
          st[r_idx] <= shared_in ? L_SM : L_M;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cs == IDLE && cpu_hs && c_hit && cpu_we && c_own)
      dat_q[c_idx] <= cpu_wdata;
    if (cs == RD_DATA && r_hs) begin
      dat_q[r_idx] <= rdata;
      tag_q[r_idx] <= r_tag;
    end
    if (cs == WT_RESP && b_hs) begin
      dat_q[r_idx] <= req_wdata;
      tag_q[r_idx] <= r_tag;
    end
  end

endmodule

// File: tb/tb_ace_line_ctrl.sv
// Directed bench for ace_line_ctrl: a negedge AXI slave model with
// programmable ready/valid stalls, and hand-computed expectations.
module tb_ace_line_ctrl;

  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0, cpu_req_ready;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [31:0] araddr;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic        wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready;
  logic        shared_in = 1'b0;
  logic        snp_valid = 1'b0, snp_ready;
  logic [31:0] snp_addr = '0;
  logic        snp_inv = 1'b0;
  logic        snp_resp_valid, snp_hit, snp_dirty;
  logic [31:0] snp_data;
  logic [3*LINES-1:0] line_state;

  ace_line_ctrl #(.LINES(LINES), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .shared_in(shared_in),
    .snp_valid(snp_valid), .snp_ready(snp_ready),
    .snp_addr(snp_addr), .snp_inv(snp_inv),
    .snp_resp_valid(snp_resp_valid), .snp_hit(snp_hit),
    .snp_dirty(snp_dirty), .snp_data(snp_data),
    .line_state(line_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // slave knobs and logs
  int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0;
  logic [31:0] rdata_v = '0;
  logic        shared_v = 1'b0;
  int          ar_w = 0, aw_w = 0, w_w = 0, r_w = 0;
  int          ar_n = 0, aw_n = 0, w_n = 0;
  logic [31:0] ar_a = '0, aw_a = '0, w_d = '0;
  int          aw_cyc = 0, w_cyc = 0, aw_bad = 0, w_bad = 0;
  logic [31:0] aw_first = '0, w_first = '0;

  initial begin
    forever begin
      @(negedge clk);
      shared_in = shared_v;
      if (arvalid) begin
        arready = (ar_w >= ar_lat);
        if (arready) begin ar_n++; ar_a = araddr; ar_w = 0; end
        else ar_w++;
      end else arready = 1'b0;
      if (awvalid) begin
        if (aw_cyc == 0) aw_first = awaddr;
        else if (awaddr != aw_first) aw_bad++;
        aw_cyc++;
        awready = (aw_w >= aw_lat);
        if (awready) begin aw_n++; aw_a = awaddr; aw_w = 0; end
        else aw_w++;
      end else awready = 1'b0;
      if (wvalid) begin
        if (w_cyc == 0) w_first = wdata;
        else if (wdata != w_first) w_bad++;
        w_cyc++;
        wready = (w_w >= w_lat);
        if (wready) begin w_n++; w_d = wdata; w_w = 0; end
        else w_w++;
      end else wready = 1'b0;
      if (rready) begin
        rdata  = rdata_v;
        rvalid = (r_w >= r_lat);
        if (rvalid) r_w = 0;
        else r_w++;
      end else rvalid = 1'b0;
      bvalid = bready;
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!cpu_req_ready && n < 50);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    lat = 0;
    while (!cpu_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("cpu_done_seen", cpu_done, 1);
    rd = cpu_rdata;
    @(posedge clk); #1;
    chk("cpu_done_pulse", cpu_done, 0);
  endtask

  task automatic snoop(input logic [31:0] a, input logic inv,
                       output logic rv, output logic h,
                       output logic dty, output logic [31:0] sd);
    int n;
    @(posedge clk); #1;
    snp_valid = 1'b1;
    snp_addr = a;
    snp_inv = inv;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!snp_ready && n < 50);
    @(posedge clk); #1;
    snp_valid = 1'b0;
    rv = snp_resp_valid;
    h = snp_hit;
    dty = snp_dirty;
    sd = snp_data;
    @(posedge clk); #1;
    chk("snp_resp_pulse", snp_resp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, n, aw0, ar0;
    logic        rv, h, dty;
    logic [31:0] sd;
    logic [3*LINES-1:0] ls;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", cpu_req_ready, 1);
    chk("rst_snp_ready", snp_ready, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_done", {cpu_done, snp_resp_valid}, 0);
    chk("rst_states", line_state, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    rst_n = 1'b1;

    // read miss from reset
    shared_v = 1'b0;
    rdata_v = 32'h1234;
    cpu_op(1'b0, 32'h1000, 32'h0, rd, lat);
    chk("miss_ar_count", ar_n, 1);
    chk("miss_araddr", ar_a, 32'h1000);
    chk("miss_rdata", rd, 32'h1234);
    chk("miss_lat", lat, 2);
    ls = line_state;
    chk("miss_state_E", ls[2:0], 4);

    // read hit
    cpu_op(1'b0, 32'h1000, 32'h0, rd, lat);
    chk("hit_lat", lat, 0);
    chk("hit_rdata", rd, 32'h1234);
    chk("hit_no_ar", ar_n, 1);

    // write hit in E
    cpu_op(1'b1, 32'h1000, 32'hBEEF, rd, lat);
    chk("wrE_lat", lat, 0);
    chk("wrE_no_aw", aw_n, 0);
    ls = line_state;
    chk("wrE_state_M", ls[2:0], 2);

    // snoop read on M line
    snoop(32'h1000, 1'b0, rv, h, dty, sd);
    chk("snpM_valid", rv, 1);
    chk("snpM_hit", h, 1);
    chk("snpM_dirty", dty, 1);
    chk("snpM_data", sd, 32'hBEEF);
    ls = line_state;
    chk("snpM_state_SM", ls[2:0], 3);

    // write-through in SM with stalled AW
    shared_v = 1'b1;
    aw_lat = 3;
    w_lat = 0;
    aw_cyc = 0;
    w_cyc = 0;
    cpu_op(1'b1, 32'h1000, 32'hCAFE, rd, lat);
    chk("wt_aw_count", aw_n, 1);
    chk("wt_awaddr", aw_a, 32'h1000);
    chk("wt_wdata", w_d, 32'hCAFE);
    chk("wt_awvalid_cycles", aw_cyc, 4);
    chk("wt_wvalid_cycles", w_cyc, 1);
    chk("wt_aw_stable", aw_bad, 0);
    chk("wt_w_stable", w_bad, 0);
    ls = line_state;
    chk("wt_state_SM", ls[2:0], 3);
    aw_lat = 0;

    snoop(32'h1000, 1'b0, rv, h, dty, sd);
    chk("snpSM_data", sd, 32'hCAFE);
    chk("snpSM_dirty", dty, 1);

    // snoop miss
    snoop(32'h9000, 1'b0, rv, h, dty, sd);
    chk("snpmiss_valid", rv, 1);
    chk("snpmiss_fields", {h, dty, sd}, 0);

    // make line M, then evict with a conflicting read
    shared_v = 1'b0;
    cpu_op(1'b1, 32'h1000, 32'h5555, rd, lat);
    ls = line_state;
    chk("wt2_state_M", ls[2:0], 2);
    aw0 = aw_n;
    ar0 = ar_n;
    shared_v = 1'b1;
    rdata_v = 32'h7777;
    cpu_op(1'b0, 32'h1040, 32'h0, rd, lat);
    chk("wb_aw_count", aw_n - aw0, 1);
    chk("wb_awaddr", aw_a, 32'h1000);
    chk("wb_wdata", w_d, 32'h5555);
    chk("wb_ar_count", ar_n - ar0, 1);
    chk("wb_araddr", ar_a, 32'h1040);
    chk("wb_rdata", rd, 32'h7777);
    ls = line_state;
    chk("wb_state_SC", ls[2:0], 1);

    // E line at index 1
    shared_v = 1'b0;
    rdata_v = 32'hA5;
    cpu_op(1'b0, 32'h2004, 32'h0, rd, lat);
    ls = line_state;
    chk("fill1_state_E", ls[5:3], 4);

    // snoop and CPU request in the same cycle
    @(posedge clk); #1;
    snp_valid = 1'b1;
    snp_addr = 32'h2004;
    snp_inv = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h1040;
    @(negedge clk);
    chk("coll_cpu_blocked", cpu_req_ready, 0);
    chk("coll_snp_ready", snp_ready, 1);
    @(posedge clk); #1;
    snp_valid = 1'b0;
    chk("coll_snp_resp", snp_resp_valid, 1);
    chk("coll_snp_hit", snp_hit, 1);
    chk("coll_snp_dirty", snp_dirty, 0);
    chk("coll_snp_data", snp_data, 32'hA5);
    ls = line_state;
    chk("coll_inv_NP", ls[5:3], 0);
    @(negedge clk);
    chk("coll_cpu_ready", cpu_req_ready, 1);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    chk("coll_cpu_done", cpu_done, 1);
    chk("coll_cpu_rdata", cpu_rdata, 32'h7777);

    // reset during RD_DATA
    r_lat = 5;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h3008;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!cpu_req_ready && n < 50);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (!rready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_in_rd_data", rready, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valids", {arvalid, rready, cpu_done, awvalid, wvalid}, 0);
    chk("rst_mid_states", line_state, 0);
    chk("rst_mid_cpu_ready", cpu_req_ready, 1);
    chk("rst_mid_snp_ready", snp_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_lat = 0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
